fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit synchronous FIFO (fifo_8bit).
- Pops one byte at a time over the FIFO's read/empty/d_out interface and serializes it onto a single async-serial line: start bit, LSB-first data, optional even parity, stop bit(s).
- Keeps a count of completed frames.
- Sits between the FIFO and the chip-level TX pin.

Parameters:
- DATA_W, 8: data bits per frame; equals FIFO data width.
- CLKS_PER_BIT, 4: clk cycles per serial bit; legal range ≥ 1.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- CNT_W, 16: width of frames_sent.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits starting new frames.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_W  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  FIFO read strobe; one-cycle pulse per byte.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.
- frames_sent  out  CNT_W  count of completed frames.

Behaviour:
- Reset (rst=1 at a rising edge) forces: state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, frames_sent=0, bit/baud counters=0.
- All outputs are registered.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0 in cycle T, go to POP.
  - Otherwise stay in IDLE.
- POP (cycle T+1): fifo_rd=1 for exactly this cycle, then go to LOAD.
- LOAD (cycle T+2): capture fifo_dout into the shift register, compute parity = XOR of the data bits, then go to START.
- START: tx=0 for CLKS_PER_BIT cycles, beginning at cycle T+3.
- DATA:
  - DATA_W bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit index runs 0..DATA_W-1.
- PARITY: present only if PARITY_EN=1; tx=parity for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: frame_done=1 and frames_sent increments. frames_sent wraps from 2^CNT_W-1 to 0.
  - Next state is always IDLE.
- Frame length: (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
- Back-to-back frames: exactly 3 cycles of tx=1 (IDLE, POP, LOAD) between the last stop cycle and the next start bit.
- fifo_empty and enable are sampled only in IDLE.
  - fifo_rd is never asserted unless fifo_empty=0 in the deciding IDLE cycle.
  - At most one fifo_rd per frame.
- enable dropping mid-frame: the current frame completes normally; no new POP occurs.
- fifo_dout changes outside LOAD: ignored.
- Reset mid-frame:
  - Next cycle tx=1, busy=0, and no frame_done is generated.
  - The popped byte is discarded.
  - frames_sent clears to 0.
- CLKS_PER_BIT=1: each bit lasts one cycle; the FSM still passes through POP and LOAD.

Test Plan:
- Single frame: defaults; FIFO holds 0xA5; enable=1 → fifo_rd pulses once. tx: start low for 4 cycles, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles (40 cycles total). frame_done pulses once on cycle 40; frames_sent=1.
- Parity: PARITY_EN=1, byte 0x07 → parity bit=1, frame is 44 cycles. Byte 0xA5 → parity bit=0.
- Back-to-back: FIFO holds 0x01, 0x80, 0xFF; enable held → 3 fifo_rd pulses and 3 frame_done pulses. Exactly 3 high cycles between frames; frames_sent=3. FIFO empty afterwards; no 4th fifo_rd.
- Gating: enable=0 with FIFO non-empty for 50 cycles → fifo_rd=0, tx=1, busy=0. Dropping enable mid-frame → frame finishes, no further pop.
- Reset mid-frame: assert rst during DATA bit 3 → next cycle tx=1, busy=0, frames_sent=0, no frame_done. After release, the next FIFO byte transmits correctly.
- Wrap: CNT_W=2, send 5 frames → frames_sent sequence 1,2,3,0,1. STOP_BITS=2 → stop high for 8 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops bytes from an upstream synchronous FIFO and serializes each one onto
// an async-serial line: start bit, LSB-first data, optional even parity,
// one or two stop bits. Keeps a wrapping count of completed frames.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       allows a new frame to start (sampled only in IDLE)
//   fifo_empty   upstream FIFO empty flag
//   fifo_dout    upstream FIFO read data, valid the cycle after fifo_rd
//   fifo_rd      one-cycle read strobe, one per frame
//   tx           serial line, idles high
//   busy         high whenever the FSM is not in IDLE
//   frame_done   one-cycle pulse on the last cycle of the final stop bit
//   frames_sent  count of completed frames, wraps
//
// state  | meaning
// IDLE   | line high, waiting for enable with FIFO non-empty
// POP    | fifo_rd strobe to the FIFO
// LOAD   | capture fifo_dout and its parity
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (only when PARITY_EN=1)
// STOP   | stop bit(s), high; frame_done on the final cycle
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [BAUD_W-1:0]   baud_cnt, baud_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic                parity, parity_n;
    logic                tx_n;
    logic                done_n;

    // Baud and bit counters are down-counters; a bit (or the whole stop
    // period) ends when both reach zero.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        parity_n = parity;

        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_n = S_POP;
                end
            end
            S_POP: begin
                state_n = S_LOAD;
            end
            S_LOAD: begin
                shreg_n  = fifo_dout;
                parity_n = ^fifo_dout;
                baud_n   = BAUD_LAST;
                state_n  = S_START;
            end
            S_START: begin
                if (baud_cnt == '0) begin
                    baud_n  = BAUD_LAST;
                    bit_n   = DATA_LAST;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_cnt == '0) begin
                    baud_n  = BAUD_LAST;
                    shreg_n = shreg >> 1;
                    if (bit_cnt == '0) begin
                        if (PARITY_EN != 0) begin
                            state_n = S_PARITY;
                        end else begin
                            bit_n   = STOP_LAST;
                            state_n = S_STOP;
                        end
                    end else begin
                        bit_n = bit_cnt - 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            S_PARITY: begin
                if (baud_cnt == '0) begin
                    baud_n  = BAUD_LAST;
                    bit_n   = STOP_LAST;
                    state_n = S_STOP;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_cnt == '0) begin
                    if (bit_cnt == '0) begin
                        state_n = S_IDLE;
                    end else begin
                        bit_n  = bit_cnt - 1'b1;
                        baud_n = BAUD_LAST;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                baud_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so that each
    // output lines up with the state it belongs to.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = parity_n;
            default:  tx_n = 1'b1;
        endcase
        done_n = (state_n == S_STOP) && (baud_n == '0) && (bit_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            tx          <= 1'b1;
            fifo_rd     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            parity     <= parity_n;
            tx         <= tx_n;
            fifo_rd    <= (state_n == S_POP);
            busy       <= (state_n != S_IDLE);
            frame_done <= done_n;
            if (done_n) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB_A = 4;
    localparam int FL_A  = (1 + 8 + 0 + 1) * CPB_A;
    localparam int CPB_B = 1;
    localparam int FL_B  = (1 + 8 + 1 + 2) * CPB_B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        fe_a, fe_b;
    logic [7:0]  dout_a = 8'h00, dout_b = 8'h00;
    logic        rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;
    logic [15:0] fs_a;
    logic [1:0]  fs_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
    int rdcnt_a = 0, rdcnt_b = 0, unf_a = 0, unf_b = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int gaps_a[$];

    logic        act_a = 1'b0, act_b = 1'b0, herr_a, herr_b;
    int          ka_a = 0, ka_b = 0, end_a = 0;
    logic [15:0] bits_a, bits_b;
    logic [15:0] cnt_a = '0;
    logic [1:0]  cnt_b = '0;
    logic [7:0]  ex_a, ex_b;
    int          done_a = 0, done_b = 0, spur_a = 0, spur_b = 0;

    assign fe_a = (wp_a == rp_a);
    assign fe_b = (wp_b == rp_b);

    fifo_uart_tx #(
        .DATA_W(8), .CLKS_PER_BIT(CPB_A), .PARITY_EN(0), .STOP_BITS(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .fifo_empty(fe_a), .fifo_dout(dout_a),
        .fifo_rd(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .frames_sent(fs_a)
    );

    fifo_uart_tx #(
        .DATA_W(8), .CLKS_PER_BIT(CPB_B), .PARITY_EN(1), .STOP_BITS(2), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .fifo_empty(fe_b), .fifo_dout(dout_b),
        .fifo_rd(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .frames_sent(fs_b)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level of every bit slot of a frame: start, data LSB first,
    // optional even parity, then stop (all unused slots stay high).
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit par_en);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (par_en) f[9] = ^d;
        return f;
    endfunction

    // FIFO models: registered read data, one entry per fifo_rd.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_a) begin
            rdcnt_a++;
            if (wp_a == rp_a) unf_a++;
            else begin
                dout_a <= mem_a[rp_a % 64];
                rp_a   <= rp_a + 1;
            end
        end
        if (rd_b) begin
            rdcnt_b++;
            if (wp_b == rp_b) unf_b++;
            else begin
                dout_b <= mem_b[rp_b % 64];
                rp_b   <= rp_b + 1;
            end
        end
    end

    // Line monitor A: captures each frame, checks bit hold, frame_done
    // position and frames_sent against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            act_a = 1'b0;
            cnt_a = '0;
        end else begin
            if (fd_a && !(act_a && ka_a == FL_A - 1)) spur_a++;
            if (!act_a && tx_a == 1'b0) begin
                act_a  = 1'b1;
                ka_a   = 0;
                bits_a = '1;
                herr_a = 1'b0;
                gaps_a.push_back(cyc - end_a - 1);
            end
            if (act_a) begin
                if (busy_a !== 1'b1) herr_a = 1'b1;
                if (ka_a % CPB_A == 0) bits_a[ka_a / CPB_A] = tx_a;
                else if (tx_a !== bits_a[ka_a / CPB_A]) herr_a = 1'b1;
                if (ka_a == FL_A - 1) begin
                    chk_eq("a_done_pulse", 32'(fd_a), 32'd1);
                    chk_eq("a_bit_hold", 32'(herr_a), 32'd0);
                    chk_eq("a_sb_nonempty", 32'(sb_a.size() != 0), 32'd1);
                    if (sb_a.size() != 0) begin
                        ex_a = sb_a.pop_front();
                        chk_eq("a_frame_bits", 32'(bits_a), 32'(frame_bits(ex_a, 1'b0)));
                    end
                    cnt_a = cnt_a + 16'd1;
                    chk_eq("a_frames_sent", 32'(fs_a), 32'(cnt_a));
                    done_a++;
                    end_a = cyc;
                    act_a = 1'b0;
                end else begin
                    ka_a++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            act_b = 1'b0;
            cnt_b = '0;
        end else begin
            if (fd_b && !(act_b && ka_b == FL_B - 1)) spur_b++;
            if (!act_b && tx_b == 1'b0) begin
                act_b  = 1'b1;
                ka_b   = 0;
                bits_b = '1;
                herr_b = 1'b0;
            end
            if (act_b) begin
                if (busy_b !== 1'b1) herr_b = 1'b1;
                if (ka_b % CPB_B == 0) bits_b[ka_b / CPB_B] = tx_b;
                else if (tx_b !== bits_b[ka_b / CPB_B]) herr_b = 1'b1;
                if (ka_b == FL_B - 1) begin
                    chk_eq("b_done_pulse", 32'(fd_b), 32'd1);
                    chk_eq("b_bit_hold", 32'(herr_b), 32'd0);
                    chk_eq("b_sb_nonempty", 32'(sb_b.size() != 0), 32'd1);
                    if (sb_b.size() != 0) begin
                        ex_b = sb_b.pop_front();
                        chk_eq("b_frame_bits", 32'(bits_b), 32'(frame_bits(ex_b, 1'b1)));
                    end
                    cnt_b = cnt_b + 2'd1;
                    chk_eq("b_frames_sent", 32'(fs_b), 32'(cnt_b));
                    done_b++;
                    act_b = 1'b0;
                end else begin
                    ka_b++;
                end
            end
        end
    end

    task automatic push_a(input logic [7:0] d);
        mem_a[wp_a % 64] = d;
        wp_a = wp_a + 1;
        sb_a.push_back(d);
    endtask

    task automatic push_b(input logic [7:0] d);
        mem_b[wp_b % 64] = d;
        wp_b = wp_b + 1;
        sb_b.push_back(d);
    endtask

    task automatic wait_done_a(input int target);
        int t = 0;
        while (done_a < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("a_wait_frames", 32'(done_a >= target), 32'd1);
    endtask

    task automatic wait_done_b(input int target);
        int t = 0;
        while (done_b < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("b_wait_frames", 32'(done_b >= target), 32'd1);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_a_outs", 32'({tx_a, busy_a, rd_a, fd_a}), 32'b1000);
        chk_eq("rst_a_fs", 32'(fs_a), 32'd0);
        chk_eq("rst_b_outs", 32'({tx_b, busy_b, rd_b, fd_b}), 32'b1000);
        chk_eq("rst_b_fs", 32'(fs_b), 32'd0);
        rst = 1'b0;

        // single frame 0xA5
        push_a(8'hA5);
        en_a = 1'b1;
        wait_done_a(1);
        chk_eq("single_rd", 32'(rdcnt_a), 32'd1);
        chk_eq("single_fs", 32'(fs_a), 32'd1);

        // back-to-back
        push_a(8'h01);
        push_a(8'h80);
        push_a(8'hFF);
        wait_done_a(4);
        chk_eq("b2b_gap2", 32'(gaps_a[gaps_a.size()-2]), 32'd3);
        chk_eq("b2b_gap3", 32'(gaps_a[gaps_a.size()-1]), 32'd3);
        chk_eq("b2b_fs", 32'(fs_a), 32'd4);
        repeat (20) @(negedge clk);
        chk_eq("b2b_rd", 32'(rdcnt_a), 32'd4);
        chk_eq("b2b_empty", 32'(fe_a), 32'd1);

        // gating with enable low
        en_a = 1'b0;
        push_a(8'h3C);
        push_a(8'hC3);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk_eq("gate_idle", 32'({rd_a, tx_a, busy_a}), 32'b010);
        end

        // enable dropped mid-frame
        en_a = 1'b1;
        t = 0;
        while (!busy_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk_eq("drop_busy", 32'(busy_a), 32'd1);
        en_a = 1'b0;
        wait_done_a(5);
        repeat (20) @(negedge clk);
        chk_eq("drop_rd", 32'(rdcnt_a), 32'd5);
        chk_eq("drop_fs", 32'(fs_a), 32'd5);
        chk_eq("drop_idle", 32'({busy_a, tx_a}), 32'b01);
        chk_eq("drop_fifo_left", 32'(fe_a), 32'd0);

        // reset during data bit 3
        push_a(8'h5A);
        en_a = 1'b1;
        t = 0;
        while (!(act_a && ka_a >= 17) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk_eq("rst_mid_reached", 32'(act_a && ka_a >= 17), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_mid_outs", 32'({tx_a, busy_a, fd_a}), 32'b100);
        chk_eq("rst_mid_fs", 32'(fs_a), 32'd0);
        @(negedge clk);
        if (sb_a.size() != 0) void'(sb_a.pop_front());
        rst = 1'b0;
        wait_done_a(6);
        chk_eq("post_rst_fs", 32'(fs_a), 32'd1);
        chk_eq("post_rst_rd", 32'(rdcnt_a), 32'd7);
        en_a = 1'b0;

        // counter wrap, parity, two stop bits, one clock per bit
        push_b(8'h07);
        push_b(8'hA5);
        push_b(8'h00);
        push_b(8'hFF);
        push_b(8'h3C);
        en_b = 1'b1;
        wait_done_b(5);
        chk_eq("wrap_fs", 32'(fs_b), 32'd1);
        repeat (10) @(negedge clk);
        chk_eq("wrap_rd", 32'(rdcnt_b), 32'd5);
        en_b = 1'b0;

        chk_eq("a_underflow", 32'(unf_a), 32'd0);
        chk_eq("b_underflow", 32'(unf_b), 32'd0);
        chk_eq("a_spurious_done", 32'(spur_a), 32'd0);
        chk_eq("b_spurious_done", 32'(spur_b), 32'd0);
        chk_eq("a_sb_left", 32'(sb_a.size()), 32'd0);
        chk_eq("b_sb_left", 32'(sb_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
